// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline stage register with load-use stall detection, flush
// bubbling, EX-stage forwarding selects and a saturating bubble counter.

package idex_hazard_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

endpackage

module idex_hazard_reg
    import idex_hazard_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    // decode-stage bundle
    input  logic             i_valid_d,
    input  logic [XLEN-1:0]  i_pc_d,
    input  logic [XLEN-1:0]  i_pcplus4_d,
    input  logic [XLEN-1:0]  i_imm_d,
    input  logic [XLEN-1:0]  i_rd1_d,
    input  logic [XLEN-1:0]  i_rd2_d,
    input  logic [4:0]       i_rs1_d,
    input  logic [4:0]       i_rs2_d,
    input  logic [4:0]       i_rd_d,
    input  alu_op_t          i_alucrtl_d,
    input  logic [1:0]       i_resultsrc_d,
    input  logic [1:0]       i_alusrc_d,
    input  logic [2:0]       i_immsrc_d,
    input  logic             i_memwrite_d,
    input  logic             i_regwrite_d,
    input  logic             i_jump_d,
    input  logic             i_branch_d,
    input  logic [2:0]       i_f3_d,
    // hazard context from later stages
    input  logic             i_flush_e,
    input  logic [4:0]       i_rd_m,
    input  logic [4:0]       i_rd_w,
    input  logic             i_regwrite_m,
    input  logic             i_regwrite_w,
    // EX-stage bundle
    output logic             o_valid_e,
    output logic [XLEN-1:0]  o_pc_e,
    output logic [XLEN-1:0]  o_pcplus4_e,
    output logic [XLEN-1:0]  o_imm_e,
    output logic [XLEN-1:0]  o_rd1_e,
    output logic [XLEN-1:0]  o_rd2_e,
    output logic [4:0]       o_rs1_e,
    output logic [4:0]       o_rs2_e,
    output logic [4:0]       o_rd_e,
    output alu_op_t          o_alucrtl_e,
    output logic [1:0]       o_resultsrc_e,
    output logic [1:0]       o_alusrc_e,
    output logic [2:0]       o_immsrc_e,
    output logic             o_memwrite_e,
    output logic             o_regwrite_e,
    output logic             o_jump_e,
    output logic             o_branch_e,
    output logic [2:0]       o_f3_e,
    // hazard outputs
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic [1:0]       o_fwda_e,
    output logic [1:0]       o_fwdb_e,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    logic lwstall;
    logic bubble;
    logic bubble_counted;
    fwd_t fwd_a;
    fwd_t fwd_b;

    // Load in EX whose destination is read by the real instruction in decode.
    always_comb begin
        lwstall = o_valid_e && o_regwrite_e && (o_resultsrc_e == 2'b01) &&
                  (o_rd_e != 5'd0) && i_valid_d &&
                  ((o_rd_e == i_rs1_d) || (o_rd_e == i_rs2_d));
        bubble         = i_flush_e || lwstall;
        bubble_counted = bubble && i_valid_d;
        // a flush kills the decode instruction, so holding it would be wrong
        o_stall_f      = lwstall && !i_flush_e;
        o_stall_d      = lwstall && !i_flush_e;
    end

    // Stage register: bubble on flush/load-use, otherwise capture decode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || bubble) begin
            o_valid_e     <= 1'b0;
            o_pc_e        <= '0;
            o_pcplus4_e   <= '0;
            o_imm_e       <= '0;
            o_rd1_e       <= '0;
            o_rd2_e       <= '0;
            o_rs1_e       <= '0;
            o_rs2_e       <= '0;
            o_rd_e        <= '0;
            o_alucrtl_e   <= ALU_ADD;
            o_resultsrc_e <= '0;
            o_alusrc_e    <= '0;
            o_immsrc_e    <= '0;
            o_memwrite_e  <= 1'b0;
            o_regwrite_e  <= 1'b0;
            o_jump_e      <= 1'b0;
            o_branch_e    <= 1'b0;
            o_f3_e        <= '0;
        end else begin
            o_valid_e     <= i_valid_d;
            o_pc_e        <= i_pc_d;
            o_pcplus4_e   <= i_pcplus4_d;
            o_imm_e       <= i_imm_d;
            o_rd1_e       <= i_rd1_d;
            o_rd2_e       <= i_rd2_d;
            o_rs1_e       <= i_rs1_d;
            o_rs2_e       <= i_rs2_d;
            o_rd_e        <= i_rd_d;
            o_alucrtl_e   <= i_alucrtl_d;
            o_resultsrc_e <= i_resultsrc_d;
            o_alusrc_e    <= i_alusrc_d;
            o_immsrc_e    <= i_immsrc_d;
            o_memwrite_e  <= i_memwrite_d;
            o_regwrite_e  <= i_regwrite_d;
            o_jump_e      <= i_jump_d;
            o_branch_e    <= i_branch_d;
            o_f3_e        <= i_f3_d;
        end
    end

    // Saturating count of bubbles that displaced a real instruction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bubble_cnt <= '0;
        end else if (bubble_counted && (o_bubble_cnt != '1)) begin
            o_bubble_cnt <= o_bubble_cnt + 1'b1;
        end
    end

    // Forwarding selects: MEM beats WB, x0 is never forwarded.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (i_regwrite_m && (i_rd_m != 5'd0) && (i_rd_m == o_rs1_e)) begin
            fwd_a = FWD_MEM;
        end else if (i_regwrite_w && (i_rd_w != 5'd0) && (i_rd_w == o_rs1_e)) begin
            fwd_a = FWD_WB;
        end
        if (i_regwrite_m && (i_rd_m != 5'd0) && (i_rd_m == o_rs2_e)) begin
            fwd_b = FWD_MEM;
        end else if (i_regwrite_w && (i_rd_w != 5'd0) && (i_rd_w == o_rs2_e)) begin
            fwd_b = FWD_WB;
        end
        o_fwda_e = fwd_a;
        o_fwdb_e = fwd_b;
    end

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Scoreboard bench for idex_hazard_reg: stimulus pushes tagged expectations,
// a negedge monitor pops and compares those due in the current cycle.

module tb_idex_hazard_reg;
    import idex_hazard_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic            valid_d;
    logic [XLEN-1:0] pc_d, pcplus4_d, imm_d, rd1_d, rd2_d;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    alu_op_t         alucrtl_d;
    logic [1:0]      resultsrc_d, alusrc_d;
    logic [2:0]      immsrc_d, f3_d;
    logic            memwrite_d, regwrite_d, jump_d, branch_d;
    logic            flush_e;
    logic [4:0]      rd_m, rd_w;
    logic            regwrite_m, regwrite_w;

    logic            valid_e, valid_e2;
    logic [XLEN-1:0] pc_e, pcplus4_e, imm_e, rd1_e, rd2_e;
    logic [XLEN-1:0] pc_e2, pcplus4_e2, imm_e2, rd1_e2, rd2_e2;
    logic [4:0]      rs1_e, rs2_e, rd_e, rs1_e2, rs2_e2, rd_e2;
    alu_op_t         alucrtl_e, alucrtl_e2;
    logic [1:0]      resultsrc_e, alusrc_e, resultsrc_e2, alusrc_e2;
    logic [2:0]      immsrc_e, f3_e, immsrc_e2, f3_e2;
    logic            memwrite_e, regwrite_e, jump_e, branch_e;
    logic            memwrite_e2, regwrite_e2, jump_e2, branch_e2;
    logic            stall_f, stall_d, stall_f2, stall_d2;
    logic [1:0]      fwda, fwdb, fwda2, fwdb2;
    logic [15:0]     cnt;
    logic [1:0]      cnt2;

    idex_hazard_reg #(.XLEN(XLEN), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_d(valid_d),
        .i_pc_d(pc_d), .i_pcplus4_d(pcplus4_d), .i_imm_d(imm_d),
        .i_rd1_d(rd1_d), .i_rd2_d(rd2_d), .i_rs1_d(rs1_d), .i_rs2_d(rs2_d),
        .i_rd_d(rd_d), .i_alucrtl_d(alucrtl_d), .i_resultsrc_d(resultsrc_d),
        .i_alusrc_d(alusrc_d), .i_immsrc_d(immsrc_d), .i_memwrite_d(memwrite_d),
        .i_regwrite_d(regwrite_d), .i_jump_d(jump_d), .i_branch_d(branch_d),
        .i_f3_d(f3_d), .i_flush_e(flush_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
        .i_regwrite_m(regwrite_m), .i_regwrite_w(regwrite_w),
        .o_valid_e(valid_e), .o_pc_e(pc_e), .o_pcplus4_e(pcplus4_e),
        .o_imm_e(imm_e), .o_rd1_e(rd1_e), .o_rd2_e(rd2_e), .o_rs1_e(rs1_e),
        .o_rs2_e(rs2_e), .o_rd_e(rd_e), .o_alucrtl_e(alucrtl_e),
        .o_resultsrc_e(resultsrc_e), .o_alusrc_e(alusrc_e),
        .o_immsrc_e(immsrc_e), .o_memwrite_e(memwrite_e),
        .o_regwrite_e(regwrite_e), .o_jump_e(jump_e), .o_branch_e(branch_e),
        .o_f3_e(f3_e), .o_stall_f(stall_f), .o_stall_d(stall_d),
        .o_fwda_e(fwda), .o_fwdb_e(fwdb), .o_bubble_cnt(cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    idex_hazard_reg #(.XLEN(XLEN), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_d(valid_d),
        .i_pc_d(pc_d), .i_pcplus4_d(pcplus4_d), .i_imm_d(imm_d),
        .i_rd1_d(rd1_d), .i_rd2_d(rd2_d), .i_rs1_d(rs1_d), .i_rs2_d(rs2_d),
        .i_rd_d(rd_d), .i_alucrtl_d(alucrtl_d), .i_resultsrc_d(resultsrc_d),
        .i_alusrc_d(alusrc_d), .i_immsrc_d(immsrc_d), .i_memwrite_d(memwrite_d),
        .i_regwrite_d(regwrite_d), .i_jump_d(jump_d), .i_branch_d(branch_d),
        .i_f3_d(f3_d), .i_flush_e(flush_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
        .i_regwrite_m(regwrite_m), .i_regwrite_w(regwrite_w),
        .o_valid_e(valid_e2), .o_pc_e(pc_e2), .o_pcplus4_e(pcplus4_e2),
        .o_imm_e(imm_e2), .o_rd1_e(rd1_e2), .o_rd2_e(rd2_e2), .o_rs1_e(rs1_e2),
        .o_rs2_e(rs2_e2), .o_rd_e(rd_e2), .o_alucrtl_e(alucrtl_e2),
        .o_resultsrc_e(resultsrc_e2), .o_alusrc_e(alusrc_e2),
        .o_immsrc_e(immsrc_e2), .o_memwrite_e(memwrite_e2),
        .o_regwrite_e(regwrite_e2), .o_jump_e(jump_e2), .o_branch_e(branch_e2),
        .o_f3_e(f3_e2), .o_stall_f(stall_f2), .o_stall_d(stall_d2),
        .o_fwda_e(fwda2), .o_fwdb_e(fwdb2), .o_bubble_cnt(cnt2)
    );

    always #5 clk = ~clk;

    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;
    int   ebub = 0;

    function automatic logic [63:0] actual(input string name);
        logic [63:0] a;
        a = '1;
        case (name)
            "valid":     a = 64'(valid_e);
            "pc":        a = 64'(pc_e);
            "imm":       a = 64'(imm_e);
            "rd1":       a = 64'(rd1_e);
            "rs1":       a = 64'(rs1_e);
            "rs2":       a = 64'(rs2_e);
            "rd":        a = 64'(rd_e);
            "alucrtl":   a = 64'(alucrtl_e);
            "resultsrc": a = 64'(resultsrc_e);
            "memwrite":  a = 64'(memwrite_e);
            "regwrite":  a = 64'(regwrite_e);
            "f3":        a = 64'(f3_e);
            "stall_f":   a = 64'(stall_f);
            "stall_d":   a = 64'(stall_d);
            "fwda":      a = 64'(fwda);
            "fwdb":      a = 64'(fwdb);
            "cnt":       a = 64'(cnt);
            "cnt2":      a = 64'(cnt2);
            "zero":      a = 64'(|{valid_e, pc_e, pcplus4_e, imm_e, rd1_e, rd2_e,
                                   rs1_e, rs2_e, rd_e, alucrtl_e, resultsrc_e,
                                   alusrc_e, immsrc_e, memwrite_e, regwrite_e,
                                   jump_e, branch_e, f3_e, cnt, cnt2});
            default:     a = '1;
        endcase
        return a;
    endfunction

    // Monitor: compare every expectation due this cycle, away from the edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == ncyc) begin
                logic [63:0] a;
                a = actual(sb[i].name);
                checks++;
                if (a !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %0h expected %0h",
                             sb[i].name, ncyc, a, sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (done) begin
            foreach (sb[i]) begin
                checks++;
                errors++;
                $display("FAIL %s never checked (due cycle %0d)", sb[i].name, sb[i].cyc);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic expect_at(input int dcyc, input string name, input logic [63:0] val);
        exp_t e;
        e.cyc  = ncyc + dcyc;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_cnt();
        expect_at(1, "cnt", 64'(ebub));
        expect_at(1, "cnt2", 64'((ebub > 3) ? 3 : ebub));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        valid_d = 0; pc_d = '0; pcplus4_d = '0; imm_d = '0; rd1_d = '0; rd2_d = '0;
        rs1_d = 0; rs2_d = 0; rd_d = 0; alucrtl_d = ALU_ADD; resultsrc_d = 0;
        alusrc_d = 0; immsrc_d = 0; memwrite_d = 0; regwrite_d = 0; jump_d = 0;
        branch_d = 0; f3_d = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic [1:0] rsrc, input logic mw);
        clear_d();
        valid_d = 1; rs1_d = rs1; rs2_d = rs2; rd_d = rd;
        regwrite_d = rw; resultsrc_d = rsrc; memwrite_d = mw;
    endtask

    initial begin
        clear_d();
        flush_e = 0; rd_m = 0; rd_w = 0; regwrite_m = 0; regwrite_w = 0;
        tick();
        tick();
        expect_at(0, "zero", 0);
        expect_at(0, "stall_f", 0);

        // add x3,x1,x2 after reset release, with distinctive payload
        rst_n = 1;
        instr(5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 1'b0);
        pc_d = 32'h100; imm_d = 32'h44; rd1_d = 32'hAAAA0001;
        alucrtl_d = ALU_OR; f3_d = 3'b010;
        expect_at(1, "rd", 3); expect_at(1, "regwrite", 1); expect_at(1, "valid", 1);
        expect_at(1, "pc", 32'h100); expect_at(1, "imm", 32'h44);
        expect_at(1, "rd1", 32'hAAAA0001);
        expect_at(1, "alucrtl", 64'(ALU_OR)); expect_at(1, "f3", 3'b010);
        tick();

        // sw in flight, then asynchronous reset mid-cycle
        instr(5'd1, 5'd2, 5'd0, 1'b0, 2'b00, 1'b1);
        tick();
        expect_at(0, "zero", 0);
        #2 rst_n = 0;
        tick();
        expect_at(0, "zero", 0);
        rst_n = 1;
        instr(5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 1'b0);
        expect_at(1, "rd", 3); expect_at(1, "regwrite", 1); expect_at(1, "valid", 1);
        tick();

        // lw x5 then add x6,x5,x1: one-cycle stall and one bubble
        instr(5'd2, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0);
        expect_at(1, "resultsrc", 1);
        tick();
        instr(5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0);
        ebub = 1;
        expect_at(0, "stall_f", 1); expect_at(0, "stall_d", 1);
        expect_at(1, "regwrite", 0); expect_at(1, "valid", 0); expect_at(1, "rd", 0);
        expect_cnt();
        tick();
        expect_at(0, "stall_f", 0); expect_at(0, "stall_d", 0);
        expect_at(1, "rd", 6); expect_at(1, "regwrite", 1);
        expect_cnt();
        tick();

        // load to x0 followed by a reader of x0: no stall
        instr(5'd2, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0);
        tick();
        instr(5'd0, 5'd0, 5'd6, 1'b1, 2'b00, 1'b0);
        expect_at(0, "stall_f", 0);
        expect_at(1, "valid", 1); expect_at(1, "rd", 6);
        expect_cnt();
        tick();

        // lw x5 with independent add x6,x7,x1: no stall
        instr(5'd2, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0);
        tick();
        instr(5'd7, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0);
        expect_at(0, "stall_d", 0);
        expect_at(1, "regwrite", 1); expect_at(1, "rs1", 7);
        expect_cnt();
        tick();

        // lw x5 then sw using x5 as rs2: stall via the rs2 match
        instr(5'd2, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0);
        tick();
        instr(5'd1, 5'd5, 5'd0, 1'b0, 2'b00, 1'b1);
        ebub = 2;
        expect_at(0, "stall_f", 1);
        expect_at(1, "memwrite", 0);
        expect_cnt();
        tick();
        expect_at(0, "stall_f", 0);
        expect_at(1, "memwrite", 1); expect_at(1, "rs2", 5);
        tick();

        // flush while decode holds sw
        instr(5'd1, 5'd2, 5'd0, 1'b0, 2'b00, 1'b1);
        flush_e = 1;
        ebub = 3;
        expect_at(1, "memwrite", 0); expect_at(1, "valid", 0);
        expect_cnt();
        tick();
        flush_e = 0;

        // flush coinciding with load-use: bubble, no stall
        instr(5'd2, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0);
        tick();
        instr(5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0);
        flush_e = 1;
        ebub = 4;
        expect_at(0, "stall_f", 0); expect_at(0, "stall_d", 0);
        expect_at(1, "valid", 0); expect_at(1, "regwrite", 0);
        expect_cnt();
        tick();

        // flush of an empty decode slot is not counted
        clear_d();
        flush_e = 1;
        expect_at(1, "valid", 0);
        expect_cnt();
        tick();
        flush_e = 0;

        // forwarding: EX holds rs1=5, rs2=5
        instr(5'd5, 5'd5, 5'd9, 1'b1, 2'b00, 1'b0);
        tick();
        rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
        expect_at(0, "fwda", 2'b10); expect_at(0, "fwdb", 2'b10);
        tick();
        rd_m = 5; regwrite_m = 0; rd_w = 5; regwrite_w = 1;
        expect_at(0, "fwda", 2'b01); expect_at(0, "fwdb", 2'b01);
        tick();
        rd_m = 0; regwrite_m = 1; rd_w = 3; regwrite_w = 1;
        expect_at(0, "fwda", 2'b00); expect_at(0, "fwdb", 2'b00);
        instr(5'd5, 5'd6, 5'd9, 1'b1, 2'b00, 1'b0);
        tick();
        rd_m = 6; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
        expect_at(0, "fwda", 2'b01); expect_at(0, "fwdb", 2'b10);
        tick();
        rd_m = 5; regwrite_m = 0; rd_w = 6; regwrite_w = 0;
        expect_at(0, "fwda", 2'b00); expect_at(0, "fwdb", 2'b00);
        flush_e = 1;
        ebub = 5;
        expect_cnt();
        tick();
        flush_e = 0;
        clear_d();
        rd_m = 0; regwrite_m = 1; rd_w = 0; regwrite_w = 1;
        expect_at(0, "rs1", 0); expect_at(0, "valid", 0);
        expect_at(0, "fwda", 2'b00); expect_at(0, "fwdb", 2'b00);
        tick();

        tick();
        tick();
        done = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL monitor did not finish");
        $fatal(1);
    end

endmodule

// File: doc/idex_hazard_reg.md
Name: idex_hazard_reg

Overview:
ID/EX pipeline stage register, directly downstream of the decode-stage controller. Captures the controller's control bundle, operands, register indices and immediates at the end of decode. Owns load-use hazard detection (stalls IF/ID, inserts a bubble) and branch/jump flush bubbling. Generates EX-stage forwarding selects and a saturating bubble counter for performance debug.

Parameters:
XLEN, 32, datapath width of operands, PC and immediate.
CNT_W, 16, width of the bubble counter.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid_d  in  1  decode slot holds a real instruction
i_pc_d, i_pcplus4_d, i_imm_d  in  XLEN  decode PC, PC+4, extended immediate
i_rd1_d, i_rd2_d  in  XLEN  register-file read data
i_rs1_d, i_rs2_d, i_rd_d  in  5  register indices
i_alucrtl_d  in  alu_op_t  ALU control from controller
i_resultsrc_d  in  2  writeback select (2'b01 = load)
i_alusrc_d  in  2  ALU source select
i_immsrc_d  in  3  immediate format (carried for debug)
i_memwrite_d, i_regwrite_d, i_jump_d, i_branch_d  in  1  control flags
i_f3_d  in  3  memory access size/sign
i_flush_e  in  1  taken branch/jump resolved in EX this cycle
i_rd_m, i_rd_w  in  5  destination in MEM / WB
i_regwrite_m, i_regwrite_w  in  1  write enables in MEM / WB
o_*_e  out  same as *_d  registered copy of every *_d input, including o_valid_e
o_stall_f, o_stall_d  out  1  hold PC and IF/ID register
o_fwda_e, o_fwdb_e  out  2  forward select: 00 regfile, 01 WB, 10 MEM
o_bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (i_rst_n=0, asynchronous): every o_*_e register goes to 0, o_valid_e=0, alucrtl goes to the all-zero encoding, and o_bubble_cnt=0.
- Reset is released synchronously to i_clk. Reset asserted mid-operation clears immediately and discards the in-flight instruction.
- lwstall (combinational): o_valid_e & o_regwrite_e & (o_resultsrc_e==2'b01) & (o_rd_e!=0) & i_valid_d & ((o_rd_e==i_rs1_d) | (o_rd_e==i_rs2_d)).
- o_stall_f = o_stall_d = lwstall & ~i_flush_e. A flush kills the decode instruction, so it must not stall.
- Each rising edge, priority order:
  - (1) i_flush_e | lwstall: load a bubble. All fields are 0, so valid, regwrite, memwrite, jump, branch = 0 and rs/rd = 0.
  - (2) otherwise: capture all *_d inputs.
  - There is no hold state: EX never stalls in this pipeline.
- Latency is 1 cycle, decode to EX outputs. A bubble with i_valid_d=0 input is simply a captured invalid slot. It does not count as an inserted bubble.
- Bubble counter increments when (i_flush_e | lwstall) & i_valid_d at the edge. It saturates at 2^CNT_W-1 and does not wrap.
- Forwarding (combinational from registered state), for A using o_rs1_e:
  - 10 if i_regwrite_m & i_rd_m!=0 & i_rd_m==o_rs1_e
  - else 01 if i_regwrite_w & i_rd_w!=0 & i_rd_w==o_rs1_e
  - else 00
  - MEM has priority over WB.
  - B is identical using o_rs2_e.
  - x0 is never forwarded.
  - A bubble (rs=0) always yields 00.
- Simultaneous flush and lwstall: bubble is inserted, no stall.
- Load to x0: never stalls.
- Back-to-back load-use: after one bubble, o_resultsrc_e is 0, so the stall lasts exactly one cycle.

Test Plan:
- Reset: hold i_rst_n=0 mid-stream with valid inputs -> all outputs are 0 asynchronously. After release plus one edge with add x3,x1,x2 (rd=3, regwrite=1) -> o_rd_e=3, o_regwrite_e=1, o_valid_e=1.
- Load-use: lw x5 then add x6,x5,x1 -> lwstall for exactly one cycle, o_stall_f=o_stall_d=1. The next EX is a bubble (regwrite_e=0), then the add enters, o_bubble_cnt=1.
- Load to x0 and load with an independent consumer (add x6,x7,x1) -> no stall, no bubble.
- Flush: i_flush_e=1 while decode holds sw (memwrite=1) -> o_memwrite_e=0, o_valid_e=0 next cycle. Assert flush and a load-use condition together -> bubble, o_stall_f=0.
- Forwarding: o_rs1_e=5 with rd_m=5/regwrite_m=1 and rd_w=5/regwrite_w=1 -> fwda=10. With only WB matching -> 01. With rd_m=0 -> 00. Repeat the same cases for B.
- Counter: CNT_W=2 with 5 flushes on valid decode -> o_bubble_cnt saturates at 3.
